mpu_stream_transpose: RTL
=========================

MPU_STREAM_TRANSPOSE -- requirements
Module: mpu_stream_transpose

Interface
REQ-001 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-002 SHALL have parameter MAX_DIM, default 5, largest square matrix side supported (2..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_dim, input, $clog2(MAX_DIM+1), matrix side N, sampled with the first element of a matrix.
REQ-006 SHALL have port cfg_mode, input, 1, 0 = transpose, 1 = pass-through copy; sampled with cfg_dim.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W): row-major input element stream.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, DATA_W) and out_last (output, 1): result element stream; out_last marks the final element.
REQ-009 SHALL have port busy, output, 1, high from the first accepted element until the last element is output.
REQ-010 SHALL have port err_dim, output, 1, sticky flag set on an illegal cfg_dim; cleared only by reset.

Function
REQ-011 SHALL store up to MAX_DIM x MAX_DIM elements in one internal buffer, indexed [row][col].
REQ-012 SHALL implement states IDLE, LOAD and DRAIN.
REQ-013 In IDLE: in_ready=1; an accepted element (in_valid&in_ready) latches cfg_dim/cfg_mode, writes buf[0][0] and moves to LOAD, or to DRAIN if N=1.
REQ-014 In LOAD: in_ready=1; each accepted element writes buf[r][c] with c incrementing and wrapping to 0 at N-1 while r increments; the element written at (N-1,N-1) moves to DRAIN.
REQ-015 In DRAIN: in_ready=0; the output index (i,j) walks row-major over N x N.
REQ-016 In DRAIN, out_data SHALL be buf[j][i] for transpose or buf[i][j] for pass-through.
REQ-017 out_valid SHALL rise the cycle after the last input element is accepted, giving a fill-to-first-output latency of 1 cycle.
REQ-018 out_valid SHALL stay high and out_data/out_last SHALL stay stable while out_ready=0, and the index SHALL advance only on out_valid&out_ready.
REQ-019 out_last SHALL be 1 exactly at index (N-1,N-1); its handshake SHALL return the FSM to IDLE with out_valid=0 the following cycle.
REQ-020 Throughput SHALL be 1 element per cycle in each direction; no input is accepted while draining (single buffer, no overlap).
REQ-021 If cfg_dim is 0 or greater than MAX_DIM when sampled, the block SHALL set err_dim and use N=MAX_DIM.
REQ-022 cfg_dim/cfg_mode changes after sampling SHALL have no effect until the next matrix.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 Asserting rst_n=0 at any time, including mid-LOAD or mid-DRAIN, SHALL immediately force state=IDLE, all counters=0, out_valid=0, out_last=0, busy=0 and err_dim=0.
REQ-025 After reset in_ready SHALL be 1, and out_data SHALL be 0.
REQ-026 Buffer contents SHALL NOT require reset; stale data SHALL never be emitted because a full load always precedes DRAIN.

Structure
REQ-027 Shared package mpu_pkg SHALL hold the FSM state enum, mode encodings (MODE_TRANSPOSE=0, MODE_COPY=1) and the default DATA_W/MAX_DIM constants.
REQ-028 Sub-module mpu_index_counter SHALL implement the (row,col) counter with runtime limit N, wrap and done outputs, and SHALL be instanced for both load and drain.
REQ-029 Buffer addressing SHALL derive from counter outputs only; there SHALL be no combinational path from in_* to out_*.

Verification
REQ-030 N=5, transpose, input 0..24 with out_ready=1 -> output 0,5,10,15,20,1,6,...,24, out_last on the 25th element, first out_valid 1 cycle after the 25th input.
REQ-031 N=3, copy mode, input 0x10..0x18 -> output 0x10..0x18 unchanged, out_last on 0x18.
REQ-032 N=1, input 0xAB -> IDLE straight to DRAIN, single output 0xAB with out_last=1, then in_ready=1.
REQ-033 N=4 transpose with out_ready toggling randomly and in_valid gaps -> 16 outputs in correct transposed order, held stable under stall, in_ready=0 throughout DRAIN.
REQ-034 cfg_dim=0 with MAX_DIM=5 -> err_dim=1, 25-element transpose; err_dim stays 1 for the next legal matrix.
REQ-035 rst_n pulsed low after 7 of 9 outputs (N=3) -> out_valid=0, busy=0 immediately; next 4-element N=2 matrix transposes correctly.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared types and defaults for the MPU stream transpose block.
package mpu_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic MODE_TRANSPOSE = 1'b0;
   localparam logic MODE_COPY      = 1'b1;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MAX_DIM = 5;
endpackage

// File: rtl/mpu_stream_transpose_if.sv
// Input and output element streams of the transpose block.
interface mpu_stream_transpose_if
   import mpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/mpu_index_counter.sv
// Row-major (row,col) walker over an lim x lim square; advances on en.
module mpu_index_counter #(
   parameter int IW = 3,
   parameter int DW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] lim,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic          wrap,
   output logic          done
);
   logic [IW-1:0] last;

   assign last = IW'(lim - DW'(1));
   assign wrap = (col == last);
   assign done = wrap && (row == last);

   // done also returns row to 0, leaving the walker ready for the next matrix
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (wrap) begin
            col <= '0;
            row <= done ? '0 : row + IW'(1);
         end else begin
            col <= col + IW'(1);
         end
      end
   end
endmodule

// File: rtl/mpu_stream_transpose.sv
// Single-buffer square matrix transpose / copy: load N*N row-major, then drain.
module mpu_stream_transpose
   import mpu_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_DIM = DEF_MAX_DIM,
   localparam int DW     = $clog2(MAX_DIM + 1),
   localparam int IW     = $clog2(MAX_DIM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DW-1:0]          cfg_dim,
   input  logic                   cfg_mode,
   mpu_stream_transpose_if.slave  s,
   output logic                   busy,
   output logic                   err_dim
);
   state_t state_q, state_d;

   logic [DW-1:0] n_q, n_in, ld_lim;
   logic          mode_q;
   logic          dim_bad;
   logic          in_fire, out_fire;
   logic [IW-1:0] ld_row, ld_col, rd_row, rd_col;
   logic          ld_wrap, ld_done, rd_wrap, rd_done;
   logic          ld_end, rd_end;
   logic [DATA_W-1:0] rd_elem;

   logic [MAX_DIM-1:0][MAX_DIM-1:0][DATA_W-1:0] mem;

   assign dim_bad  = (cfg_dim == '0) || (cfg_dim > DW'(MAX_DIM));
   assign n_in     = dim_bad ? DW'(MAX_DIM) : cfg_dim;
   assign in_fire  = s.in_valid && s.in_ready;
   assign out_fire = s.out_valid && s.out_ready;

   // The first element is written before n_q is loaded, so the load walker
   // must see the freshly sampled size while idle.
   assign ld_lim = (state_q == ST_IDLE) ? n_in : n_q;

   mpu_index_counter #(.IW(IW), .DW(DW)) u_ld_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_fire),
      .lim   (ld_lim),
      .row   (ld_row),
      .col   (ld_col),
      .wrap  (ld_wrap),
      .done  (ld_done)
   );

   mpu_index_counter #(.IW(IW), .DW(DW)) u_rd_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (out_fire),
      .lim   (n_q),
      .row   (rd_row),
      .col   (rd_col),
      .wrap  (rd_wrap),
      .done  (rd_done)
   );

   assign ld_end = ld_wrap && ld_done;
   assign rd_end = rd_wrap && rd_done;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (in_fire) state_d = (n_in == DW'(1)) ? ST_DRAIN : ST_LOAD;
         ST_LOAD:  if (in_fire && ld_end) state_d = ST_DRAIN;
         ST_DRAIN: if (out_fire && rd_end) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         mode_q  <= MODE_TRANSPOSE;
         err_dim <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && in_fire) begin
            n_q    <= n_in;
            mode_q <= cfg_mode;
            if (dim_bad) err_dim <= 1'b1;
         end
      end
   end

   // Buffer needs no reset: DRAIN is only reachable after a full load.
   always_ff @(posedge clk) begin
      if (in_fire) mem[ld_row][ld_col] <= s.in_data;
   end

   assign rd_elem = (mode_q == MODE_COPY) ? mem[rd_row][rd_col] : mem[rd_col][rd_row];

   assign s.in_ready  = (state_q != ST_DRAIN);
   assign s.out_valid = (state_q == ST_DRAIN);
   assign s.out_last  = s.out_valid && rd_end;
   assign s.out_data  = s.out_valid ? rd_elem : '0;
   assign busy        = (state_q != ST_IDLE);
endmodule
